game_tick_rx: RTL and testbench
===============================

GAME_TICK_RX -- requirements
Module: game_tick_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth (>=2).
REQ-002 SHALL have parameter SPAWN_DIV, default 60, game ticks per spawn_tick (>=1).
REQ-003 SHALL have parameter FIRE_DIV, default 8, game ticks per fire_tick (>=1).
REQ-004 SHALL have parameter TIMEOUT, default 2000000, clk cycles without a toggle edge before tick_lost.
REQ-005 SHALL have parameter FRAME_W, default 16, frame counter width.
REQ-006 SHALL have port clk, input, 1, system clock; one clock domain.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port tick_toggle, input, 1, game-rate toggle signal; each level change marks one game tick.
REQ-009 SHALL have port pause, input, 1, level request to freeze game timing.
REQ-010 SHALL have port frame_clr, input, 1, synchronous one-cycle clear of frame and divider counters.
REQ-011 SHALL have port tick, output, 1, one-cycle pulse per accepted game tick.
REQ-012 SHALL have port spawn_tick, output, 1, one-cycle pulse every SPAWN_DIV accepted ticks.
REQ-013 SHALL have port fire_tick, output, 1, one-cycle pulse every FIRE_DIV accepted ticks.
REQ-014 SHALL have port frame_cnt, output, FRAME_W, accepted-tick count, wrapping.
REQ-015 SHALL have port paused, output, 1, high while in PAUSED state.
REQ-016 SHALL have port tick_lost, output, 1, sticky timeout flag.

Function
REQ-017 SHALL pass tick_toggle through SYNC_STAGES flops plus one history flop; edge = last sync stage XOR history flop (either polarity).
REQ-018 SHALL register all outputs; tick rises on the (SYNC_STAGES+1)th rising clk edge after the edge that first samples a new tick_toggle level.
REQ-019 SHALL implement states INIT, RUN, PAUSED.
REQ-020 INIT: entered on reset, lasts SYNC_STAGES+1 cycles; edges detected during INIT are discarded; then RUN.
REQ-021 RUN: edge -> tick=1, frame_cnt+1 (mod 2^FRAME_W), both divider counters +1.
REQ-022 RUN with pause=1 -> PAUSED next cycle; an edge in that same cycle is still accepted (current state decides).
REQ-023 PAUSED: edges produce no tick/spawn_tick/fire_tick; all counters hold; paused=1; pause=0 -> RUN next cycle.
REQ-024 Spawn divider counts 0..SPAWN_DIV-1; an accepted edge while at SPAWN_DIV-1 sets spawn_tick=1 in the tick cycle and wraps to 0; fire divider identical with FIRE_DIV.
REQ-025 SPAWN_DIV=1 or FIRE_DIV=1 SHALL pulse on every tick.
REQ-026 frame_clr SHALL zero frame_cnt and both dividers in any state; on a simultaneous edge in RUN, tick still pulses but counters end at 0 and spawn_tick/fire_tick stay 0.
REQ-027 Watchdog counts clk cycles since last detected edge in RUN and PAUSED, saturating at TIMEOUT; reaching TIMEOUT sets tick_lost.
REQ-028 Any detected edge (RUN or PAUSED) SHALL zero the watchdog and clear tick_lost in the following cycle.
REQ-029 Watchdog width SHALL be ceil(log2(TIMEOUT+1)) bits; no wrap.

Reset
REQ-030 rst=1 SHALL asynchronously force state INIT, all sync/history flops 0, tick=spawn_tick=fire_tick=0, frame_cnt=0, dividers 0, watchdog 0, paused=0, tick_lost=0.
REQ-031 rst asserted mid-operation SHALL abort pending pulses; after release no tick until INIT completes and a new edge arrives.
REQ-032 tick_toggle=1 at reset release SHALL NOT produce a tick (edge absorbed by INIT).

Verification (SYNC_STAGES=2, SPAWN_DIV=3, FIRE_DIV=2, TIMEOUT=20, FRAME_W=4)
REQ-033 Toggle tick_toggle once after INIT -> tick high exactly 3 edges later for 1 cycle, frame_cnt=1.
REQ-034 6 toggles spaced 10 cycles -> 6 ticks, spawn_tick with ticks 3 and 6, fire_tick with ticks 2,4,6, frame_cnt=6.
REQ-035 pause=1, 4 toggles, pause=0 -> paused=1 throughout, no pulses, frame_cnt unchanged; next toggle resumes counting.
REQ-036 No toggle for 20 cycles -> tick_lost=1 and stays; next toggle -> tick_lost=0 one cycle after detection.
REQ-037 frame_clr coincident with the edge of tick 3 -> tick=1, spawn_tick=0, frame_cnt=0; 17 further ticks -> frame_cnt wraps to 1.
REQ-038 tick_toggle=1 during rst, release -> no tick; rst pulsed mid-run -> all outputs 0 immediately.

Source files
------------

// File: rtl/game_tick_rx.sv
// rtl/game_tick_rx.sv - game-rate toggle receiver: synchronised tick, spawn/fire dividers, pause and watchdog
// Converts each level change of an asynchronous toggle into one tick pulse and derived game timing.
module game_tick_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int SPAWN_DIV   = 60,
  parameter int FIRE_DIV    = 8,
  parameter int TIMEOUT     = 2000000,
  parameter int FRAME_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_toggle,
  input  logic               pause,
  input  logic               frame_clr,
  output logic               tick,
  output logic               spawn_tick,
  output logic               fire_tick,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic               paused,
  output logic               tick_lost
);

  localparam int SP_W   = $clog2(SPAWN_DIV + 1);
  localparam int FI_W   = $clog2(FIRE_DIV + 1);
  localparam int WD_W   = $clog2(TIMEOUT + 1);
  localparam int INIT_W = $clog2(SYNC_STAGES + 1);

  localparam logic [SP_W-1:0]   SP_LAST   = SP_W'(SPAWN_DIV - 1);
  localparam logic [FI_W-1:0]   FI_LAST   = FI_W'(FIRE_DIV - 1);
  localparam logic [WD_W-1:0]   WD_LIMIT  = WD_W'(TIMEOUT);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(SYNC_STAGES);

  localparam logic [1:0] S_INIT   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_PAUSED = 2'd2;

  logic [SYNC_STAGES-1:0] sync;
  logic                   hist;
  logic                   edge_det;
  logic [1:0]             state;
  logic [1:0]             state_next;
  logic [INIT_W-1:0]      init_cnt;
  logic [SP_W-1:0]        spawn_cnt;
  logic [FI_W-1:0]        fire_cnt;
  logic [WD_W-1:0]        wd_cnt;
  logic [WD_W-1:0]        wd_inc;

  assign edge_det = sync[SYNC_STAGES-1] ^ hist;
  assign wd_inc   = (wd_cnt == WD_LIMIT) ? wd_cnt : wd_cnt + 1'b1;

  always_comb begin
    state_next = state;
    case (state)
      S_INIT:   if (init_cnt == INIT_LAST) state_next = S_RUN;
      S_RUN:    if (pause) state_next = S_PAUSED;
      S_PAUSED: if (!pause) state_next = S_RUN;
      default:  state_next = S_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync       <= '0;
      hist       <= 1'b0;
      state      <= S_INIT;
      init_cnt   <= '0;
      tick       <= 1'b0;
      spawn_tick <= 1'b0;
      fire_tick  <= 1'b0;
      frame_cnt  <= '0;
      spawn_cnt  <= '0;
      fire_cnt   <= '0;
      wd_cnt     <= '0;
      paused     <= 1'b0;
      tick_lost  <= 1'b0;
    end else begin
      sync       <= {sync[SYNC_STAGES-2:0], tick_toggle};
      hist       <= sync[SYNC_STAGES-1];
      state      <= state_next;
      paused     <= (state_next == S_PAUSED);
      tick       <= 1'b0;
      spawn_tick <= 1'b0;
      fire_tick  <= 1'b0;

      if (state == S_INIT) begin
        init_cnt <= init_cnt + 1'b1;
      end

      // The current state decides acceptance, so an edge alongside a pause request still counts.
      if (state == S_RUN && edge_det) begin
        tick      <= 1'b1;
        frame_cnt <= frame_cnt + 1'b1;
        if (spawn_cnt == SP_LAST) begin
          spawn_tick <= 1'b1;
          spawn_cnt  <= '0;
        end else begin
          spawn_cnt <= spawn_cnt + 1'b1;
        end
        if (fire_cnt == FI_LAST) begin
          fire_tick <= 1'b1;
          fire_cnt  <= '0;
        end else begin
          fire_cnt <= fire_cnt + 1'b1;
        end
      end

      if (state == S_RUN || state == S_PAUSED) begin
        if (edge_det) begin
          wd_cnt    <= '0;
          tick_lost <= 1'b0;
        end else begin
          wd_cnt    <= wd_inc;
          tick_lost <= tick_lost | (wd_inc == WD_LIMIT);
        end
      end

      // Clear wins over a coincident tick's counter updates; the tick pulse itself survives.
      if (frame_clr) begin
        frame_cnt  <= '0;
        spawn_cnt  <= '0;
        fire_cnt   <= '0;
        spawn_tick <= 1'b0;
        fire_tick  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_game_tick_rx.sv
// tb/tb_game_tick_rx.sv - directed self-checking bench for game_tick_rx
module tb_game_tick_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_toggle;
  logic       pause;
  logic       frame_clr;
  logic       tick;
  logic       spawn_tick;
  logic       fire_tick;
  logic [3:0] frame_cnt;
  logic       paused;
  logic       tick_lost;

  int checks = 0;
  int errors = 0;

  game_tick_rx #(
    .SYNC_STAGES(2), .SPAWN_DIV(3), .FIRE_DIV(2), .TIMEOUT(20), .FRAME_W(4)
  ) dut (
    .clk(clk), .rst(rst), .tick_toggle(tick_toggle), .pause(pause),
    .frame_clr(frame_clr), .tick(tick), .spawn_tick(spawn_tick),
    .fire_tick(fire_tick), .frame_cnt(frame_cnt), .paused(paused),
    .tick_lost(tick_lost)
  );

  always #5 clk = ~clk;

  // Flip the toggle mid-cycle and report which rising edge (1 = sampling edge) carried the tick.
  task automatic toggle_wait(output int lat, output logic sp, output logic fi);
    lat = 0; sp = 1'b0; fi = 1'b0;
    @(negedge clk);
    tick_toggle = ~tick_toggle;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk);
      #1;
      if (tick === 1'b1) begin
        lat = i; sp = spawn_tick; fi = fire_tick;
        break;
      end
    end
  endtask

  task automatic clear_pulse();
    @(negedge clk);
    frame_clr = 1'b1;
    @(negedge clk);
    frame_clr = 1'b0;
  endtask

  task automatic test_reset();
    int ticks_seen;
    rst = 1'b1; tick_toggle = 1'b1; pause = 1'b0; frame_clr = 1'b0;
    #12;
    checks++;
    if ({tick, spawn_tick, fire_tick, frame_cnt, paused, tick_lost} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0", {tick, spawn_tick, fire_tick, frame_cnt, paused, tick_lost});
    end
    @(negedge clk);
    rst = 1'b0;
    ticks_seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (tick === 1'b1) ticks_seen++;
    end
    checks++;
    if (ticks_seen !== 0) begin
      errors++;
      $display("FAIL reset_high_toggle ticks got %0d want 0", ticks_seen);
    end
    checks++;
    if (paused !== 1'b0 || tick_lost !== 1'b0 || frame_cnt !== 4'd0) begin
      errors++;
      $display("FAIL post_reset_state paused %b lost %b frame %0d want 0 0 0", paused, tick_lost, frame_cnt);
    end
  endtask

  task automatic test_single();
    int lat; logic sp, fi;
    toggle_wait(lat, sp, fi);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL single_latency got %0d want 3", lat);
    end
    checks++;
    if (frame_cnt !== 4'd1 || sp !== 1'b0 || fi !== 1'b0) begin
      errors++;
      $display("FAIL single_counts frame %0d sp %b fi %b want 1 0 0", frame_cnt, sp, fi);
    end
    @(posedge clk); #1;
    checks++;
    if (tick !== 1'b0) begin
      errors++;
      $display("FAIL single_width tick got %b want 0", tick);
    end
  endtask

  task automatic test_dividers();
    int lat; logic sp, fi;
    logic exp_sp, exp_fi;
    clear_pulse();
    checks++;
    if (frame_cnt !== 4'd0) begin
      errors++;
      $display("FAIL clear_frame got %0d want 0", frame_cnt);
    end
    for (int k = 1; k <= 6; k++) begin
      toggle_wait(lat, sp, fi);
      exp_sp = (k % 3 == 0);
      exp_fi = (k % 2 == 0);
      checks++;
      if (lat !== 3 || sp !== exp_sp || fi !== exp_fi || frame_cnt !== 4'(k)) begin
        errors++;
        $display("FAIL divider_tick%0d lat %0d sp %b fi %b frame %0d want 3 %b %b %0d",
                 k, lat, sp, fi, frame_cnt, exp_sp, exp_fi, k);
      end
      repeat (7) @(posedge clk);
    end
  endtask

  task automatic test_pause();
    int lat; logic sp, fi;
    int bad;
    @(negedge clk);
    pause = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (paused !== 1'b1) begin
      errors++;
      $display("FAIL pause_enter paused got %b want 1", paused);
    end
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tick_toggle = ~tick_toggle;
      repeat (8) begin
        @(posedge clk); #1;
        if (paused !== 1'b1 || tick !== 1'b0 || spawn_tick !== 1'b0 || fire_tick !== 1'b0) bad++;
      end
    end
    checks++;
    if (bad !== 0 || frame_cnt !== 4'd6) begin
      errors++;
      $display("FAIL pause_hold bad_cycles %0d frame %0d want 0 6", bad, frame_cnt);
    end
    @(negedge clk);
    pause = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (paused !== 1'b0) begin
      errors++;
      $display("FAIL pause_exit paused got %b want 0", paused);
    end
    toggle_wait(lat, sp, fi);
    checks++;
    if (lat !== 3 || frame_cnt !== 4'd7 || sp !== 1'b0 || fi !== 1'b0) begin
      errors++;
      $display("FAIL pause_resume lat %0d frame %0d sp %b fi %b want 3 7 0 0", lat, frame_cnt, sp, fi);
    end
  endtask

  task automatic test_timeout();
    logic lost_before, lost_at, tick_at;
    repeat (25) @(posedge clk);
    #1;
    checks++;
    if (tick_lost !== 1'b1) begin
      errors++;
      $display("FAIL timeout_set got %b want 1", tick_lost);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (tick_lost !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky got %b want 1", tick_lost);
    end
    @(negedge clk);
    tick_toggle = ~tick_toggle;
    @(posedge clk);
    @(posedge clk); #1;
    lost_before = tick_lost;
    @(posedge clk); #1;
    lost_at = tick_lost;
    tick_at = tick;
    checks++;
    if (lost_before !== 1'b1 || lost_at !== 1'b0 || tick_at !== 1'b1 || frame_cnt !== 4'd8) begin
      errors++;
      $display("FAIL timeout_clear before %b at %b tick %b frame %0d want 1 0 1 8",
               lost_before, lost_at, tick_at, frame_cnt);
    end
  endtask

  task automatic test_clear_wrap();
    int lat; logic sp, fi;
    int sp_cnt, fi_cnt;
    clear_pulse();
    toggle_wait(lat, sp, fi);
    toggle_wait(lat, sp, fi);
    @(negedge clk);
    tick_toggle = ~tick_toggle;
    @(posedge clk);
    @(posedge clk); #1;
    frame_clr = 1'b1;
    @(posedge clk); #1;
    frame_clr = 1'b0;
    checks++;
    if (tick !== 1'b1 || spawn_tick !== 1'b0 || fire_tick !== 1'b0 || frame_cnt !== 4'd0) begin
      errors++;
      $display("FAIL clear_on_edge tick %b sp %b fi %b frame %0d want 1 0 0 0",
               tick, spawn_tick, fire_tick, frame_cnt);
    end
    sp_cnt = 0; fi_cnt = 0;
    for (int k = 0; k < 17; k++) begin
      toggle_wait(lat, sp, fi);
      if (sp === 1'b1) sp_cnt++;
      if (fi === 1'b1) fi_cnt++;
      repeat (2) @(posedge clk);
    end
    checks++;
    if (frame_cnt !== 4'd1) begin
      errors++;
      $display("FAIL frame_wrap got %0d want 1", frame_cnt);
    end
    checks++;
    if (sp_cnt !== 5 || fi_cnt !== 8) begin
      errors++;
      $display("FAIL wrap_dividers spawn %0d fire %0d want 5 8", sp_cnt, fi_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic sp, fi;
    int ticks_seen;
    @(negedge clk);
    tick_toggle = ~tick_toggle;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({tick, spawn_tick, fire_tick, frame_cnt, paused, tick_lost} !== 9'b0) begin
      errors++;
      $display("FAIL reset_mid_outputs got %b want 0", {tick, spawn_tick, fire_tick, frame_cnt, paused, tick_lost});
    end
    @(negedge clk);
    rst = 1'b0;
    ticks_seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (tick === 1'b1) ticks_seen++;
    end
    checks++;
    if (ticks_seen !== 0) begin
      errors++;
      $display("FAIL reset_mid_abort ticks got %0d want 0", ticks_seen);
    end
    toggle_wait(lat, sp, fi);
    checks++;
    if (lat !== 3 || frame_cnt !== 4'd1) begin
      errors++;
      $display("FAIL reset_mid_resume lat %0d frame %0d want 3 1", lat, frame_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_dividers();
    test_pause();
    test_timeout();
    test_clear_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit exceeded");
    $fatal(1);
  end

endmodule
